// File: rtl/timer_pkg.sv
// Shared types and default sizes for the interval timer controller.
package timer_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_PRESCALE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } timer_state_t;

endpackage

// File: rtl/timer_count_dp.sv
// Settable up-counter: loads value when set is high, otherwise advances by STRIDE.
// Holding is done by setting the counter to its own value.
module timer_count_dp #(
    parameter int WIDTH  = 32,
    parameter int STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] count
);

    // Counter register; wraps modulo 2^WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (set)
            count <= value;
        else
            count <= count + WIDTH'(STRIDE);
    end

endmodule

// File: rtl/timer_ctrl.sv
// Interval timer controller: sequences timer_count_dp through load/run/hold,
// compares against a match value and emits a registered one-cycle match pulse,
// one-shot or with periodic auto-reload.
// Optional macro TIMER_CTRL_PRESCALE_EN adds a RUN-cycle prescaler so the
// counter only advances (and compares) every cfg_prescale_i+1 cycles.
//
// state | meaning
// IDLE  | counter held, config accepted, waiting for start_i
// LOAD  | counter loaded with start value
// RUN   | counter advancing, compare active
// DONE  | one-shot matched, counter held, return to IDLE
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH            = DEF_WIDTH,
    parameter int INCREMENT_AMOUNT = 1
`ifdef TIMER_CTRL_PRESCALE_EN
    ,
    parameter int PRESCALE_W       = DEF_PRESCALE_W
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [WIDTH-1:0]      cfg_start_i,
    input  logic [WIDTH-1:0]      cfg_match_i,
    input  logic                  cfg_periodic_i,
`ifdef TIMER_CTRL_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] cfg_prescale_i,
`endif
    input  logic                  start_i,
    input  logic                  stop_i,
    output logic                  busy_o,
    output logic                  match_o,
    output logic [WIDTH-1:0]      count_o
);

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] start_r, match_r;
    logic             periodic_r;
    logic             match_d, match_q;
    logic             dp_set;
    logic [WIDTH-1:0] dp_value;
    logic             cfg_fire;
    logic             hit;
    logic             tick;

    assign cfg_ready_o = (state_q == IDLE);
    assign cfg_fire    = cfg_valid_i && cfg_ready_o;
    assign busy_o      = (state_q != IDLE);
    assign match_o     = match_q;
    assign hit         = (count_o == match_r);

    // Shadow config registers, written only while IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_r    <= '0;
            match_r    <= '0;
            periodic_r <= 1'b0;
        end else if (cfg_fire) begin
            start_r    <= cfg_start_i;
            match_r    <= cfg_match_i;
            periodic_r <= cfg_periodic_i;
        end
    end

`ifdef TIMER_CTRL_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_r, pre_q;

    assign tick = (pre_q == prescale_r);

    // Prescale divisor capture and RUN-cycle divider, restarted in LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_r <= '0;
            pre_q      <= '0;
        end else begin
            if (cfg_fire)
                prescale_r <= cfg_prescale_i;
            if (state_q == LOAD)
                pre_q <= '0;
            else if (state_q == RUN)
                pre_q <= tick ? '0 : pre_q + 1'b1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // State register and registered match pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
        end
    end

    // Next-state and counter control; default is to hold the counter.
    always_comb begin
        state_d  = state_q;
        match_d  = 1'b0;
        dp_set   = 1'b1;
        dp_value = count_o;
        unique case (state_q)
            IDLE: begin
                if (start_i)
                    state_d = LOAD;
            end
            LOAD: begin
                dp_value = start_r;
                state_d  = stop_i ? IDLE : RUN;
            end
            RUN: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (hit) begin
                        match_d = 1'b1;
                        if (periodic_r)
                            dp_value = start_r;
                        else
                            state_d = DONE;
                    end else begin
                        dp_set = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    timer_count_dp #(
        .WIDTH  (WIDTH),
        .STRIDE (INCREMENT_AMOUNT)
    ) u_count_dp (
        .clk   (clk),
        .rst_n (rst_n),
        .set   (dp_set),
        .value (dp_value),
        .count (count_o)
    );

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl (WIDTH=8, stride 1) with a scoreboard of
// expected per-cycle outputs; covers TIMER_CTRL_PRESCALE_EN when defined.
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_start = '0;
    logic [7:0] cfg_match = '0;
    logic       cfg_periodic = 1'b0;
`ifdef TIMER_CTRL_PRESCALE_EN
    logic [7:0] cfg_prescale = '0;
`endif
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       busy;
    logic       match;
    logic [7:0] count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] cnt;
        logic       m;
        logic       b;
        logic       r;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    always #5 clk = ~clk;

    timer_ctrl #(
        .WIDTH            (8),
        .INCREMENT_AMOUNT (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid_i    (cfg_valid),
        .cfg_ready_o    (cfg_ready),
        .cfg_start_i    (cfg_start),
        .cfg_match_i    (cfg_match),
        .cfg_periodic_i (cfg_periodic),
`ifdef TIMER_CTRL_PRESCALE_EN
        .cfg_prescale_i (cfg_prescale),
`endif
        .start_i        (start),
        .stop_i         (stop),
        .busy_o         (busy),
        .match_o        (match),
        .count_o        (count)
    );

    // Pop one expectation per falling edge and compare against the outputs.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            checks++;
            assert (count === cur.cnt) else begin
                errors++;
                $error("FAIL count got=%0h exp=%0h t=%0t", count, cur.cnt, $time);
            end
            checks++;
            assert (match === cur.m) else begin
                errors++;
                $error("FAIL match got=%0b exp=%0b t=%0t", match, cur.m, $time);
            end
            checks++;
            assert (busy === cur.b) else begin
                errors++;
                $error("FAIL busy got=%0b exp=%0b t=%0t", busy, cur.b, $time);
            end
            checks++;
            assert (cfg_ready === cur.r) else begin
                errors++;
                $error("FAIL ready got=%0b exp=%0b t=%0t", cfg_ready, cur.r, $time);
            end
        end
    end

    // Drive inputs for the next rising edge and queue the outputs expected after it.
    task automatic step(input logic v, input logic st, input logic sp,
                        input logic [7:0] ec, input logic em, input logic eb, input logic er);
        exp_t e;
        @(negedge clk);
        #1;
        cfg_valid = v;
        start     = st;
        stop      = sp;
        e.cnt = ec;
        e.m   = em;
        e.b   = eb;
        e.r   = er;
        sb.push_back(e);
    endtask

    task automatic check_idle_now(input string tag);
        checks++;
        assert (count === 8'h00 && busy === 1'b0 && match === 1'b0 && cfg_ready === 1'b1) else begin
            errors++;
            $error("FAIL %s got cnt=%0h busy=%0b match=%0b ready=%0b exp cnt=0 busy=0 match=0 ready=1",
                   tag, count, busy, match, cfg_ready);
        end
    endtask

    initial begin
        #2;
        check_idle_now("reset_state");
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // One-shot 10 -> 13.
        cfg_start = 8'd10; cfg_match = 8'd13; cfg_periodic = 1'b0;
        step(1, 1, 0, 8'd0,  0, 1, 0);
        step(0, 0, 0, 8'd10, 0, 1, 0);
        step(0, 0, 0, 8'd11, 0, 1, 0);
        step(0, 0, 0, 8'd12, 0, 1, 0);
        step(0, 0, 0, 8'd13, 0, 1, 0);
        step(0, 0, 0, 8'd13, 1, 1, 0);
        step(0, 0, 0, 8'd13, 0, 0, 1);
        step(0, 0, 0, 8'd13, 0, 0, 1);

        // Periodic 10..12, stop while count is 11; start_i held high in RUN is ignored.
        cfg_start = 8'd10; cfg_match = 8'd12; cfg_periodic = 1'b1;
        step(1, 1, 0, 8'd13, 0, 1, 0);
        step(0, 1, 0, 8'd10, 0, 1, 0);
        step(0, 1, 0, 8'd11, 0, 1, 0);
        step(0, 0, 0, 8'd12, 0, 1, 0);
        step(0, 0, 0, 8'd10, 1, 1, 0);
        step(0, 0, 0, 8'd11, 0, 1, 0);
        step(0, 0, 0, 8'd12, 0, 1, 0);
        step(0, 0, 0, 8'd10, 1, 1, 0);
        step(0, 0, 0, 8'd11, 0, 1, 0);
        step(0, 0, 1, 8'd11, 0, 0, 1);
        step(0, 0, 0, 8'd11, 0, 0, 1);

        // Periodic again, stop while count is 12: stop beats the hit.
        step(1, 1, 0, 8'd11, 0, 1, 0);
        step(0, 0, 0, 8'd10, 0, 1, 0);
        step(0, 0, 0, 8'd11, 0, 1, 0);
        step(0, 0, 0, 8'd12, 0, 1, 0);
        step(0, 0, 1, 8'd12, 0, 0, 1);
        step(0, 0, 0, 8'd12, 0, 0, 1);

        // Wrap-around one-shot FE -> 01.
        cfg_start = 8'hFE; cfg_match = 8'h01; cfg_periodic = 1'b0;
        step(1, 1, 0, 8'd12,  0, 1, 0);
        step(0, 0, 0, 8'hFE,  0, 1, 0);
        step(0, 0, 0, 8'hFF,  0, 1, 0);
        step(0, 0, 0, 8'h00,  0, 1, 0);
        step(0, 0, 0, 8'h01,  0, 1, 0);
        step(0, 0, 0, 8'h01,  1, 1, 0);
        step(0, 0, 0, 8'h01,  0, 0, 1);

        // Config attempt during RUN must be refused and not disturb the run.
        cfg_start = 8'd10; cfg_match = 8'd12; cfg_periodic = 1'b1;
        step(1, 1, 0, 8'h01, 0, 1, 0);
        step(0, 0, 0, 8'd10, 0, 1, 0);
        cfg_start = 8'd50; cfg_match = 8'd60; cfg_periodic = 1'b0;
        step(1, 0, 0, 8'd11, 0, 1, 0);
        step(1, 0, 0, 8'd12, 0, 1, 0);
        step(0, 0, 0, 8'd10, 1, 1, 0);

        // Asynchronous reset while match_o is high.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_now("async_reset");
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Shadow registers cleared by reset: start==match==0 hits in first RUN cycle.
        step(0, 1, 0, 8'd0, 0, 1, 0);
        step(0, 0, 0, 8'd0, 0, 1, 0);
        step(0, 0, 0, 8'd0, 1, 1, 0);
        step(0, 0, 0, 8'd0, 0, 0, 1);

`ifdef TIMER_CTRL_PRESCALE_EN
        // Prescale 2: count advances every third RUN cycle.
        cfg_start = 8'd0; cfg_match = 8'd2; cfg_periodic = 1'b0; cfg_prescale = 8'd2;
        step(1, 1, 0, 8'd0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'd0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'd1, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'd2, 0, 1, 0);
        step(0, 0, 0, 8'd2, 1, 1, 0);
        step(0, 0, 0, 8'd2, 0, 0, 1);
`endif

        @(negedge clk);
        #1;
        checks++;
        assert (sb.size() === 0) else begin
            errors++;
            $error("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Programmable interval timer controller that sequences a settable up-counter datapath through load, run and hold via the counter's set/value interface. A config handshake supplies start value, match value and mode. The controller emits a one-cycle match pulse and supports one-shot or periodic auto-reload. It sits between the management/config bus and the counter, acting as the timebase for interrupt and event generation.

Parameters:
WIDTH, 32, counter, start and match width in bits
INCREMENT_AMOUNT, 1, counter stride per advance; must be at least 1

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cfg_valid_i  input  1  config transfer request
cfg_ready_o  output  1  config accepted when high with cfg_valid_i
cfg_start_i  input  WIDTH  value loaded at start and on periodic reload
cfg_match_i  input  WIDTH  compare value
cfg_periodic_i  input  1  1 = auto-reload on match; 0 = one-shot
start_i  input  1  begin a run (sampled only in IDLE)
stop_i  input  1  abort a run (sampled in LOAD/RUN)
busy_o  output  1  state != IDLE
match_o  output  1  registered one-cycle pulse per match
count_o  output  WIDTH  current counter value

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low, ports clk and rst_n.
- Reset: state IDLE, count_o=0, match_o=0, busy_o=0, cfg_ready_o=1, start_r=0, match_r=0, periodic_r=0. Assertion mid-operation aborts immediately with no pending pulse.
- Config: cfg_ready_o = (state==IDLE), combinational. On cfg_valid_i&&cfg_ready_o, capture start_r, match_r and periodic_r at the clock edge. Requests outside IDLE are not accepted.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: hold the counter (set=1, value=count_o). start_i -> LOAD. If start_i and a config handshake occur in the same cycle, LOAD uses the new config.
- LOAD: set=1, value=start_r -> RUN. count_o=start_r in the first RUN cycle. stop_i in LOAD -> IDLE; count_o is still loaded with start_r.
- RUN: counter advances by INCREMENT_AMOUNT modulo 2^WIDTH each cycle (set=0).
  - hit = (count_o == match_r), equality only.
  - On hit: match_o=1 in the next cycle.
  - On hit with periodic_r=1: set=1, value=start_r, so the next count is start_r and the state stays RUN. Period = (match-start)/INC + 1 cycles.
  - On hit with periodic_r=0: hold the counter and go to DONE.
- DONE: hold the counter -> IDLE next cycle.
- stop_i in RUN: hold the counter -> IDLE. stop_i wins over a hit in the same cycle; no match_o.
- Unreachable match (stride skips it): the counter wraps indefinitely until stop_i. match_r==start_r: hit in the first RUN cycle.
- start_i outside IDLE is ignored. count_o stays valid and readable at all times.

Optional Feature:
TIMER_CTRL_PRESCALE_EN:
- Enabled: adds parameter PRESCALE_W (default 8) and input cfg_prescale_i [PRESCALE_W], captured with the other config.
- A prescale counter, cleared in LOAD and on each tick, generates a tick every (cfg_prescale+1) RUN cycles. The counter advances, and hits are evaluated, only on tick cycles; it holds otherwise.
- Prescale 0 is identical to the feature being absent.
- Disabled: no port or parameter; the counter advances every RUN cycle.

Decomposition:
- Package timer_pkg holds:
  - state typedef enum (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3)
  - default WIDTH and PRESCALE_W localparams
- One natural sub-module, timer_count_dp: settable up-counter with async active-low reset and set/value/stride. The controller owns only the FSM, shadow registers, compare and optional prescaler.

Test Plan:
- WIDTH=8, config start=10, match=13, one-shot, start_i at edge t -> busy_o rises at t+1; count_o 10,11,12,13 at t+2..t+5; match_o high only at t+6 (state DONE, count 13); IDLE and busy_o=0 at t+7; count held at 13.
- Periodic start=10, match=12 -> count 10,11,12,10,11,12...; match_o pulses every 3 cycles, one cycle after each 12; busy_o stays 1.
- Periodic run, stop_i asserted while count=11 -> IDLE next edge, count_o held at 11, no match_o; stop_i while count=12 -> no match_o, count holds 12.
- Wrap: start=8'hFE, match=8'h01 -> FE,FF,00,01, then a single match_o.
- cfg_valid_i during RUN -> cfg_ready_o=0 and the run is unaffected. rst_n low mid-RUN -> count_o=0, busy_o=0 and match_o=0 asynchronously, cfg_ready_o=1.
- TIMER_CTRL_PRESCALE_EN with prescale=2, start=0, match=2 -> count changes every 3 cycles; match_o fires once, 1 cycle after count reaches 2.
